// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline-stage definitions.
// Holds the skid-stage state encoding, the per-stage payload layouts with
// their widths (used to size DATA_W at each stage boundary) and the NOP
// bubble payloads that stages present while empty.
package pipe_stage_skid_pkg;

  // EMPTY: nothing held; ONE: main register valid; FULL: main + skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } idex_t;

  localparam int IFID_W = $bits(ifid_t);
  localparam int IDEX_W = $bits(idex_t);

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0};
  localparam idex_t IDEX_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0,
                                    rs1_val: 32'h0, rs2_val: 32'h0};

  function automatic logic [1:0] occ_of(skid_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, clears the count
//   clr_i  - synchronous clear (takes priority over increment)
//   inc_i  - add one this cycle unless already at all-ones
//   cnt_o  - current count, sticks at 2^CNT_W-1
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid
// buffer. in_ready_o comes straight from a flop, so downstream ready never
// reaches upstream combinationally; the skid entry absorbs the one payload
// that arrives in the cycle downstream stops accepting.
// Ports:
//   clk_i        - clock
//   start_i      - asynchronous active-low reset
//   flush_i      - synchronous flush, drops all held entries
//   in_valid_i / in_ready_o / in_data_i    - upstream handshake
//   out_valid_o / out_ready_i / out_data_o - downstream handshake
//   occ_o        - number of entries held (0..2)
//   stall_cnt_o  - saturating count of cycles with out_valid_o && !out_ready_i
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire;
  logic              out_fire;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = m_q;
  assign occ_o       = occ_of(state_q);

  assign in_fire  = in_valid_i && in_ready_q;
  assign out_fire = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush_i) begin
      // An in-fire this cycle is discarded; an out-fire has already been
      // seen by downstream and needs no undo.
      state_d = ST_EMPTY;
      m_d     = BUBBLE;
      s_d     = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            m_d     = in_data_i;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            m_d = in_data_i;
          end else if (in_fire) begin
            state_d = ST_FULL;
            s_d     = in_data_i;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            m_d     = BUBBLE;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            m_d     = s_q;
            s_d     = BUBBLE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          m_d     = BUBBLE;
          s_d     = BUBBLE;
        end
      endcase
    end
    // Precomputed from the next state so the output is a plain flop.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q    <= ST_EMPTY;
      m_q        <= BUBBLE;
      s_q        <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (start_i),
    .clr_i  (1'b0),
    .inc_i  (out_valid_o && !out_ready_i),
    .cnt_o  (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int          DW      = 16;
  localparam int          CW      = 4;
  localparam logic [15:0] BUB     = 16'hDEAD;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          start;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_skid #(
    .DATA_W (DW),
    .BUBBLE (BUB),
    .CNT_W  (CW)
  ) dut (
    .clk_i       (clk),
    .start_i     (start),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .occ_o       (occ),
    .stall_cnt_o (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vin;
    logic [15:0] din;
    logic        rdy;
    logic        fl;
    logic        e_valid;
    logic [15:0] e_data;
    logic        e_ready;
    logic [1:0]  e_occ;
    int          e_stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  // Leaves time at posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [15:0] ed,
                         input logic er, input logic [1:0] eo, input int es);
    chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".data"},  32'(out_data),  32'(ed));
    chk({tag, ".ready"}, 32'(in_ready),  32'(er));
    chk({tag, ".occ"},   32'(occ),       32'(eo));
    chk({tag, ".stall"}, 32'(stall_cnt), 32'(es));
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(logic vin, logic [15:0] din, logic rdy, logic fl,
                              logic ev, logic [15:0] ed, logic er, logic [1:0] eo, int es);
    vec_t v;
    v.vin = vin; v.din = din; v.rdy = rdy; v.fl = fl;
    v.e_valid = ev; v.e_data = ed; v.e_ready = er; v.e_occ = eo; v.e_stall = es;
    return v;
  endfunction

  logic [15:0] mq[$];
  int          m_stall;

  initial begin
    start = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);

    // Streaming 0x1..0x8 with out_ready high: one-cycle latency, occ <= 1.
    vecs.push_back(mk(1, 16'h1, 1, 0, 0, BUB,   1, 0, 0));
    for (int i = 2; i <= 8; i++)
      vecs.push_back(mk(1, 16'(i), 1, 0, 1, 16'(i - 1), 1, 1, 0));
    vecs.push_back(mk(0, 16'h0, 1, 0, 1, 16'h8, 1, 1, 0));
    vecs.push_back(mk(0, 16'h0, 1, 0, 0, BUB,   1, 0, 0));
    // Back-pressure: 0xA at output when ready drops; 0xB into skid; 0xC held off.
    vecs.push_back(mk(1, 16'hA, 1, 0, 0, BUB,   1, 0, 0));
    vecs.push_back(mk(1, 16'hB, 0, 0, 1, 16'hA, 1, 1, 0));
    vecs.push_back(mk(1, 16'hC, 0, 0, 1, 16'hA, 0, 2, 1));
    vecs.push_back(mk(1, 16'hC, 0, 0, 1, 16'hA, 0, 2, 2));
    vecs.push_back(mk(1, 16'hC, 1, 0, 1, 16'hA, 0, 2, 3));
    vecs.push_back(mk(1, 16'hC, 1, 0, 1, 16'hB, 1, 1, 3));
    vecs.push_back(mk(0, 16'h0, 1, 0, 1, 16'hC, 1, 1, 3));
    vecs.push_back(mk(0, 16'h0, 1, 0, 0, BUB,   1, 0, 3));
    // Flush while FULL with 0x55 offered, then flush held with 0x66 offered.
    vecs.push_back(mk(1, 16'h31, 0, 0, 0, BUB,    1, 0, 3));
    vecs.push_back(mk(1, 16'h32, 0, 0, 1, 16'h31, 1, 1, 3));
    vecs.push_back(mk(1, 16'h55, 0, 1, 1, 16'h31, 0, 2, 4));
    vecs.push_back(mk(1, 16'h66, 1, 1, 0, BUB,    1, 0, 5));
    vecs.push_back(mk(0, 16'h0,  1, 0, 0, BUB,    1, 0, 5));
    vecs.push_back(mk(0, 16'h0,  1, 0, 0, BUB,    1, 0, 5));

    do_reset();
    chk_all("reset", 1'b0, BUB, 1'b1, 2'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].vin, vecs[i].din, vecs[i].rdy, vecs[i].fl);
      #2;
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
              vecs[i].e_ready, vecs[i].e_occ, vecs[i].e_stall);
      tick();
    end

    // Reset asserted mid-FULL, checked with no clock edge in between.
    do_reset();
    drive(1'b1, 16'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h22, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    chk("midfull.occ_before", 32'(occ), 32'd2);
    chk("midfull.data_before", 32'(out_data), 32'h11);
    #1;
    start = 1'b0;
    #1;
    chk_all("rst_async", 1'b0, BUB, 1'b1, 2'd0, 0);
    tick();
    start = 1'b1;

    // Saturation of the 4-bit stall counter.
    do_reset();
    drive(1'b1, 16'h77, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      #2;
      chk($sformatf("sat.cnt%0d", k), 32'(stall_cnt), 32'((k < CNT_MAX) ? k : CNT_MAX));
      chk($sformatf("sat.data%0d", k), 32'(out_data), 32'h77);
      tick();
    end
    #2;
    chk("sat.final", 32'(stall_cnt), 32'(CNT_MAX));

    // Randomised run against a queue model of the stage.
    do_reset();
    mq.delete();
    m_stall = 0;
    for (int c = 0; c < 10000; c++) begin
      logic        v, r, f, acc, ov;
      logic [15:0] d;
      v = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      r = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 63) == 0);
      drive(v, d, r, f);
      #2;
      ov = (mq.size() != 0);
      chk_all($sformatf("rnd%0d", c), ov, ov ? mq[0] : BUB,
              (mq.size() < 2), 2'(mq.size()), m_stall);
      acc = v && (mq.size() < 2);
      if (ov && r) void'(mq.pop_front());
      if (ov && !r && m_stall < CNT_MAX) m_stall++;
      if (f) mq.delete();
      else if (acc) mq.push_back(d);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a saturating back-pressure counter. It replaces hand-written per-stage latches (IF/ID, ID/EX, …) with one block. Stall becomes back-pressure through `out_ready_i` instead of a global hold. Every stage boundary gets full throughput and a registered `in_ready_o`, which breaks the combinational ready path.

## Interface
Parameters:
- `DATA_W`, default 64: payload width; the IF/ID instance packs instr[31:0] and pc[31:0].
- `BUBBLE`, default `'0`: payload value presented whenever `out_valid_o` is 0.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `start_i`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  synchronous flush; drops all held entries.
- `in_valid_i`  in  1  upstream has a payload.
- `in_ready_o`  out  1  stage can accept; registered output.
- `in_data_i`  in  DATA_W  upstream payload.
- `out_valid_o`  out  1  downstream payload valid.
- `out_ready_i`  in  1  downstream accepts.
- `out_data_o`  out  DATA_W  downstream payload.
- `occ_o`  out  2  entries held: 0, 1 or 2.
- `stall_cnt_o`  out  CNT_W  cycles with `out_valid_o && !out_ready_i`; saturates.

## Operation
- Handshake events:
  - in-fire = `in_valid_i && in_ready_o`.
  - out-fire = `out_valid_o && out_ready_i`.
  - Data is transferred only on a fire.
- Storage:
  - main register M drives `out_data_o`.
  - skid register S holds one extra entry.
- States: EMPTY (occ 0), ONE (M valid), FULL (M and S valid).
- Transitions, in the absence of flush:
  - EMPTY: in-fire → ONE, with M ← in_data.
  - ONE:
    - in-fire with out-fire → ONE, M ← in_data.
    - in-fire without out-fire → FULL, S ← in_data.
    - out-fire without in-fire → EMPTY, M ← BUBBLE.
    - Otherwise hold.
  - FULL: `in_ready_o` = 0; out-fire → ONE, M ← S, S ← BUBBLE; otherwise hold.
- Derived outputs:
  - `in_ready_o` = (state != FULL), taken from a register and not from `out_ready_i`.
  - `out_valid_o` = (state != EMPTY).
  - `out_data_o` = M; M equals BUBBLE whenever the state is EMPTY.
- Flush:
  - Next state is EMPTY; M and S ← BUBBLE.
  - An in-fire in the flush cycle is discarded; an out-fire in the flush cycle still counts as delivered.
  - Flush does not clear `stall_cnt_o`.
- Reset (`start_i` low, any time including mid-transfer):
  - Immediately: state EMPTY, M = S = BUBBLE, `out_valid_o` 0, `in_ready_o` 1, `occ_o` 0, `stall_cnt_o` 0.
  - Release is synchronised by the surrounding design; the block is not responsible for it.
- Stall counter:
  - Increments by 1 each cycle `out_valid_o && !out_ready_i` holds.
  - Holds at 2^CNT_W−1 and never wraps.
- Ordering: payloads leave in acceptance order; no payload is duplicated or dropped except by flush or reset.

## Timing
- Latency: in-fire in cycle n → `out_valid_o` with that payload in cycle n+1.
- Throughput: one transfer per cycle while `out_ready_i` stays high; occupancy stays ≤1.
- Back-pressure:
  - When `out_ready_i` drops, one further payload is absorbed into S.
  - `in_ready_o` falls in the following cycle.
  - `in_ready_o` rises the cycle after the first out-fire from FULL.
- Paths:
  - No combinational path from `out_ready_i` to `in_ready_o`.
  - No combinational path from `in_data_i` to `out_data_o`.
- Flush:
  - Asserted in cycle n → `out_valid_o` = 0 and `in_ready_o` = 1 in cycle n+1.
  - With flush held, the stage stays EMPTY.

## Structure
- A shared pipeline package holds:
  - the state enum (EMPTY, ONE, FULL);
  - the per-stage payload typedefs (`ifid_t` {instr, pc}, …) and their widths, used to set DATA_W;
  - the default BUBBLE constants (NOP payload).
- One sub-module: `sat_counter` (CNT_W, increment enable, synchronous clear unused) for `stall_cnt_o`, reused by the perf-counter block.

## Test plan
- Reset mid-FULL:
  - Stimulus: fill with 0x11, 0x22 while `out_ready_i`=0, then pulse `start_i` low.
  - Required: `out_valid_o`=0, `occ_o`=0, `out_data_o`=BUBBLE and `stall_cnt_o`=0 without waiting for a clock edge.
- Streaming:
  - Stimulus: `out_ready_i`=1; present 0x1..0x8 on consecutive cycles.
  - Required: outputs appear one cycle later, one per cycle, in order; `occ_o` ≤1; `in_ready_o` constantly 1.
- Back-pressure:
  - Stimulus: stream 0xA, 0xB, 0xC; drop `out_ready_i` when 0xA is at the output; hold it low 3 cycles.
  - Required: 0xB is absorbed into S; `in_ready_o`=0 for 3 cycles; 0xC is not accepted; `stall_cnt_o`=3; on release, 0xA, 0xB, 0xC are delivered in order.
- Flush while FULL with in_valid:
  - Stimulus: assert `flush_i` together with `in_valid_i` carrying 0x55.
  - Required: next cycle EMPTY, `out_data_o`=BUBBLE, `in_ready_o`=1; 0x55 never appears at the output.
- Saturation:
  - Stimulus: CNT_W=4, hold valid with `out_ready_i`=0 for 20 cycles.
  - Required: `stall_cnt_o` reaches 15 and stays at 15.
- Random check:
  - Stimulus: random valid/ready/flush over 10k cycles, with a scoreboard.
  - Required: order is preserved, there are no duplicates, and losses occur only across flush.
